// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain test sequencer.
package scan_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-in / serial-out shift register (shifts toward the MSB).
module scan_shift_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         ser_in,
    output logic [W-1:0] q
);

    // Load has priority over shift; serial data enters at bit 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], ser_in};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequences one scan chain through load, capture and unload, returning the captured contents.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN  = 16,
    parameter int unsigned CAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result_out
);

    import scan_ctrl_pkg::*;

    localparam int unsigned      CNT_W     = $clog2(CHAIN_LEN + CAP_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAP_CYCLES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   scan_en_d;
    logic                   busy_d;
    logic                   done_d;
    logic [CHAIN_LEN-1:0]   result_d;

    logic                   stim_load;
    logic [CHAIN_LEN-1:0]   stim_val;
    logic                   stim_shift;
    logic                   rsp_shift;
    logic [CHAIN_LEN-1:0]   stim_q;
    logic [CHAIN_LEN-1:0]   rsp_q;
    logic                   unused_bits;

    // Stimulus register: MSB drives the chain head; zeros fill behind so scan_in idles low.
    scan_shift_reg #(.W(CHAIN_LEN)) u_stim (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (stim_load),
        .load_val (stim_val),
        .shift    (stim_shift),
        .ser_in   (1'b0),
        .q        (stim_q)
    );

    // Response register: collects the chain tail, first bit sampled ends at the MSB.
    scan_shift_reg #(.W(CHAIN_LEN)) u_rsp (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (1'b0),
        .load_val ('0),
        .shift    (rsp_shift),
        .ser_in   (scan_out),
        .q        (rsp_q)
    );

    assign scan_in     = stim_q[CHAIN_LEN-1];
    assign unused_bits = ^{stim_q[CHAIN_LEN-2:0], rsp_q[CHAIN_LEN-1]};

    // Next-state, counter and output decode; abort returns to IDLE and parks the chain head low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scan_en_d  = scan_en;
        busy_d     = busy;
        done_d     = 1'b0;
        result_d   = result_out;
        stim_load  = 1'b0;
        stim_val   = '0;
        stim_shift = 1'b0;
        rsp_shift  = 1'b0;

        if (abort && (state_q == ST_LOAD || state_q == ST_CAPTURE || state_q == ST_UNLOAD)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            scan_en_d = 1'b0;
            busy_d    = 1'b0;
            stim_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d   = ST_LOAD;
                        cnt_d     = '0;
                        scan_en_d = 1'b1;
                        busy_d    = 1'b1;
                        stim_load = 1'b1;
                        stim_val  = pattern_in;
                    end
                end
                ST_LOAD: begin
                    stim_shift = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        state_d   = ST_CAPTURE;
                        cnt_d     = '0;
                        scan_en_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_q == CAP_LAST) begin
                        state_d   = ST_UNLOAD;
                        cnt_d     = '0;
                        scan_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_UNLOAD: begin
                    rsp_shift = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        state_d   = ST_DONE;
                        cnt_d     = '0;
                        scan_en_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        result_d  = {rsp_q[CHAIN_LEN-2:0], scan_out};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    scan_en_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            scan_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_out <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_en    <= scan_en_d;
            busy       <= busy_d;
            done       <= done_d;
            result_out <= result_d;
        end
    end

endmodule
